// File: rtl/frac_mult_pipe_ccff.sv
// frac_mult_pipe_ccff: pipelined fracturable multiplier/accumulator whose modes come from a local config chain
//   prog_clk/pResetn      : clock, asynchronous active-low reset
//   config_enable/ccff_*  : shift the 3-bit mode chain {ACC,SIGNED,FRAC}; datapath flushed while shifting
//   in_valid/acc_clr/a/b  : sample input, acc_clr restarts the accumulator for that sample
//   out_valid/y           : one-cycle pulse when y (product or running sum) updates
module frac_mult_pipe_ccff #(
  parameter int WIDTH       = 18,
  parameter int PIPE_STAGES = 2,
  parameter int CFG_BITS    = 3
) (
  input  logic                 prog_clk,
  input  logic                 pResetn,
  input  logic                 config_enable,
  input  logic                 ccff_head,
  output logic                 ccff_tail,
  input  logic                 in_valid,
  input  logic                 acc_clr,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  output logic [2*WIDTH-1:0]   y
);
  localparam int H  = WIDTH / 2;
  localparam int SW = 2 * WIDTH + 2;
  logic [CFG_BITS-1:0] cfg;
  logic frac, sgn, acc, keep;
  logic [2*WIDTH-1:0] ae, be, pf, prod, fp, full_sum, ynext;
  logic [WIDTH-1:0] alo, blo, ahi, bhi, plo, phi, slo, shi;
  logic [SW-1:0] s_in, s_out;
  assign frac = cfg[0];
  assign sgn = cfg[1];
  assign acc = cfg[2];
  assign ccff_tail = cfg[CFG_BITS-1];
  // Operands are extended to the product width first so one unsigned multiply
  // yields the correct two's-complement or unsigned result modulo the width.
  always_comb begin
    ae = {{WIDTH{sgn & a[WIDTH-1]}}, a};
    be = {{WIDTH{sgn & b[WIDTH-1]}}, b};
    alo = {{H{sgn & a[H-1]}}, a[H-1:0]};
    blo = {{H{sgn & b[H-1]}}, b[H-1:0]};
    ahi = {{H{sgn & a[WIDTH-1]}}, a[WIDTH-1:H]};
    bhi = {{H{sgn & b[WIDTH-1]}}, b[WIDTH-1:H]};
    pf = ae * be;
    plo = alo * blo;
    phi = ahi * bhi;
    prod = frac ? {phi, plo} : pf;
    s_in = {in_valid & ~config_enable, acc_clr, prod};
  end
  generate
    if (PIPE_STAGES == 1) begin : g_np
      assign s_out = s_in;
    end else begin : g_p
      logic [SW-1:0] rg [PIPE_STAGES-1];
      always_ff @(posedge prog_clk or negedge pResetn)
        if (!pResetn)
          for (int i = 0; i < PIPE_STAGES - 1; i++) rg[i] <= '0;
        else if (config_enable)
          for (int i = 0; i < PIPE_STAGES - 1; i++) rg[i] <= '0;
        else begin
          rg[0] <= s_in;
          for (int i = 1; i < PIPE_STAGES - 1; i++) rg[i] <= rg[i-1];
        end
      assign s_out = rg[PIPE_STAGES-2];
    end
  endgenerate
  // Lane sums are formed separately so no carry crosses the lane boundary.
  always_comb begin
    fp = s_out[2*WIDTH-1:0];
    keep = acc & ~s_out[SW-2];
    full_sum = (keep ? y : '0) + fp;
    slo = (keep ? y[WIDTH-1:0] : '0) + fp[WIDTH-1:0];
    shi = (keep ? y[2*WIDTH-1:WIDTH] : '0) + fp[2*WIDTH-1:WIDTH];
    ynext = frac ? {shi, slo} : full_sum;
  end
  always_ff @(posedge prog_clk or negedge pResetn)
    if (!pResetn) begin
      cfg <= '0;
      y <= '0;
      out_valid <= 1'b0;
    end else begin
      if (config_enable) cfg <= {cfg[CFG_BITS-2:0], ccff_head};
      out_valid <= s_out[SW-1] & ~config_enable;
      if (s_out[SW-1] & ~config_enable) y <= ynext;
    end
endmodule
